// File: rtl/servant_wb_arbiter.sv
`default_nettype none
// ============================================================================
// servant_wb_arbiter
// Round-robin two-master Wishbone arbiter with a bus-timeout watchdog.
// Revision: 1.0
// ============================================================================
module servant_wb_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_m0_adr,
  input  logic [31:0] i_wb_m0_dat,
  input  logic [3:0]  i_wb_m0_sel,
  input  logic        i_wb_m0_we,
  input  logic        i_wb_m0_cyc,
  output logic [31:0] o_wb_m0_rdt,
  output logic        o_wb_m0_ack,
  input  logic [31:0] i_wb_m1_adr,
  input  logic [31:0] i_wb_m1_dat,
  input  logic [3:0]  i_wb_m1_sel,
  input  logic        i_wb_m1_we,
  input  logic        i_wb_m1_cyc,
  output logic [31:0] o_wb_m1_rdt,
  output logic        o_wb_m1_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_timeout,
  output logic [7:0]  o_err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last;
  logic [15:0] r_cnt;
  logic [7:0]  r_err_count;

  logic w_busy;
  logic w_sel1;
  logic w_req_cyc;
  logic w_fwd_ack;
  logic w_tmo;
  logic w_done;

  assign w_busy    = (r_state != IDLE);
  assign w_sel1    = (r_state == BUSY1);
  assign w_req_cyc = w_sel1 ? i_wb_m1_cyc : i_wb_m0_cyc;
  assign w_fwd_ack = w_busy & w_req_cyc & i_wb_ack;
  // A real ack in the limit cycle takes priority over the forced termination.
  assign w_tmo     = w_busy & w_req_cyc & ~i_wb_ack & (r_cnt == 16'(TIMEOUT));
  assign w_done    = w_fwd_ack | w_tmo;

  assign o_wb_adr = w_sel1 ? i_wb_m1_adr : i_wb_m0_adr;
  assign o_wb_dat = w_sel1 ? i_wb_m1_dat : i_wb_m0_dat;
  assign o_wb_sel = w_sel1 ? i_wb_m1_sel : i_wb_m0_sel;
  assign o_wb_we  = w_sel1 ? i_wb_m1_we  : i_wb_m0_we;
  assign o_wb_cyc = w_busy & w_req_cyc;

  // Reset drops an in-flight cycle, so acks are suppressed while it is held.
  assign o_wb_m0_ack = i_rst_n & (r_state == BUSY0) & w_done;
  assign o_wb_m1_ack = i_rst_n & w_sel1 & w_done;
  assign o_wb_m0_rdt = w_tmo ? ERR_DATA : i_wb_rdt;
  assign o_wb_m1_rdt = w_tmo ? ERR_DATA : i_wb_rdt;
  assign o_timeout   = i_rst_n & w_tmo;
  assign o_err_count = r_err_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (i_wb_m0_cyc && (!i_wb_m1_cyc || r_last))
            r_state <= BUSY0;
          else if (i_wb_m1_cyc)
            r_state <= BUSY1;
        end
        BUSY0, BUSY1: begin
          if (!w_req_cyc || w_done) begin
            r_state <= IDLE;
            r_last  <= w_sel1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
          if (w_tmo && (r_err_count != 8'hFF))
            r_err_count <= r_err_count + 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_servant_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_servant_wb_arbiter
// Directed and random stimulus against a transaction-level arbiter model.
// Revision: 1.0
// ============================================================================
module tb_servant_wb_arbiter;

  localparam int          TMO  = 4;
  localparam logic [31:0] ERRW = 32'hDEADBEEF;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic        m_cyc [2];
  logic [31:0] o_wb_m0_rdt, o_wb_m1_rdt;
  logic        o_wb_m0_ack, o_wb_m1_ack;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_cyc;
  logic [31:0] s_rdt = 32'h0;
  logic        s_ack = 1'b0;
  logic        o_timeout;
  logic [7:0]  o_err_count;

  servant_wb_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERRW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wb_m0_adr (m_adr[0]),
    .i_wb_m0_dat (m_dat[0]),
    .i_wb_m0_sel (m_sel[0]),
    .i_wb_m0_we  (m_we[0]),
    .i_wb_m0_cyc (m_cyc[0]),
    .o_wb_m0_rdt (o_wb_m0_rdt),
    .o_wb_m0_ack (o_wb_m0_ack),
    .i_wb_m1_adr (m_adr[1]),
    .i_wb_m1_dat (m_dat[1]),
    .i_wb_m1_sel (m_sel[1]),
    .i_wb_m1_we  (m_we[1]),
    .i_wb_m1_cyc (m_cyc[1]),
    .o_wb_m1_rdt (o_wb_m1_rdt),
    .o_wb_m1_ack (o_wb_m1_ack),
    .o_wb_adr    (o_wb_adr),
    .o_wb_dat    (o_wb_dat),
    .o_wb_sel    (o_wb_sel),
    .o_wb_we     (o_wb_we),
    .o_wb_cyc    (o_wb_cyc),
    .i_wb_rdt    (s_rdt),
    .i_wb_ack    (s_ack),
    .o_timeout   (o_timeout),
    .o_err_count (o_err_count)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: who owns the bus, how long it has waited.
  int owner = -1;
  int last  = 1;
  int age   = 0;
  int errc  = 0;

  logic        obs_cyc, obs_tmo;
  logic        obs_ack [2];
  logic [31:0] obs_rdt [2];
  logic [7:0]  obs_err;

  int slave_mode = 0;  // 0 manual, 1 never ack, 2 ack next cycle, 3 random
  logic auto_m [2];
  int   req_pct  = 100;
  logic abort_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    int          src;
    logic        c, lim, e_tmo;
    logic        e_ack [2];
    logic [31:0] e_rdt;
    @(negedge i_clk);
    src   = (owner == 1) ? 1 : 0;
    c     = (owner >= 0) && m_cyc[src];
    lim   = (owner >= 0) && (age == TMO);
    e_tmo = i_rst_n && c && !s_ack && lim;
    for (int n = 0; n < 2; n++)
      e_ack[n] = i_rst_n && (owner == n) && m_cyc[n] && (s_ack || lim);
    e_rdt = e_tmo ? ERRW : s_rdt;

    obs_cyc    = o_wb_cyc;
    obs_tmo    = o_timeout;
    obs_ack[0] = o_wb_m0_ack;
    obs_ack[1] = o_wb_m1_ack;
    obs_rdt[0] = o_wb_m0_rdt;
    obs_rdt[1] = o_wb_m1_rdt;
    obs_err    = o_err_count;

    check_val("cyc", 32'(o_wb_cyc), 32'(c));
    check_val("adr", o_wb_adr, m_adr[src]);
    check_val("dat", o_wb_dat, m_dat[src]);
    check_val("sel", 32'(o_wb_sel), 32'(m_sel[src]));
    check_val("we", 32'(o_wb_we), 32'(m_we[src]));
    check_val("ack0", 32'(o_wb_m0_ack), 32'(e_ack[0]));
    check_val("ack1", 32'(o_wb_m1_ack), 32'(e_ack[1]));
    check_val("timeout", 32'(o_timeout), 32'(e_tmo));
    check_val("err_count", 32'(o_err_count), 32'(errc));
    if (e_ack[0]) check_val("rdt0", o_wb_m0_rdt, e_rdt);
    if (e_ack[1]) check_val("rdt1", o_wb_m1_rdt, e_rdt);

    if (!i_rst_n) begin
      owner = -1; last = 1; age = 0; errc = 0;
    end else if (owner < 0) begin
      if (m_cyc[0] && m_cyc[1]) owner = (last == 0) ? 1 : 0;
      else if (m_cyc[0])        owner = 0;
      else if (m_cyc[1])        owner = 1;
      age = 0;
    end else if (!c || e_ack[0] || e_ack[1]) begin
      if (e_tmo && errc < 255) errc++;
      last  = owner;
      owner = -1;
    end else begin
      age++;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive();
    if (slave_mode == 1) s_ack = 1'b0;
    else if (slave_mode == 2) s_ack = obs_cyc && !s_ack;
    else if (slave_mode == 3) begin
      s_ack = obs_cyc && !s_ack && ($urandom_range(0, 3) != 0);
      s_rdt = $urandom;
    end
    for (int n = 0; n < 2; n++) begin
      if (auto_m[n]) begin
        if (m_cyc[n]) begin
          if (obs_ack[n] || (abort_en && $urandom_range(0, 15) == 0)) m_cyc[n] = 1'b0;
        end else if ($urandom_range(0, 99) < req_pct) begin
          m_cyc[n] = 1'b1;
          m_adr[n] = $urandom;
          m_dat[n] = $urandom;
          m_sel[n] = 4'($urandom);
          m_we[n]  = 1'($urandom);
        end
      end
    end
  endtask

  task automatic cycle();
    tick();
    drive();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    s_ack   = 1'b0;
    @(posedge i_clk);
    #1;
    owner = -1; last = 1; age = 0; errc = 0;
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic idle_masters();
    for (int n = 0; n < 2; n++) begin
      auto_m[n] = 1'b0;
      m_cyc[n]  = 1'b0;
      m_we[n]   = 1'b0;
    end
  endtask

  initial begin
    int k, cnt, nb, first;
    int   grants [4];
    logic got, seen_tmo;
    logic [31:0] seen_rdt;

    for (int n = 0; n < 2; n++) begin
      m_adr[n] = 32'h1000 * (n + 1);
      m_dat[n] = 32'hA0A0_0000 + n;
      m_sel[n] = 4'hF;
    end
    idle_masters();

    // Single m0 read with a one-cycle slave.
    do_reset();
    slave_mode = 2;
    s_rdt      = 32'h12345678;
    m_cyc[0]   = 1'b1;
    k = -1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_ack[0]) begin
        k = i;
        seen_rdt = obs_rdt[0];
        break;
      end
    end
    check_val("m0_ack_latency", 32'(k), 32'd2);
    check_val("m0_read_data", seen_rdt, 32'h12345678);
    m_cyc[0] = 1'b0;
    cycle();
    check_val("cyc_low_after_ack", 32'(obs_cyc), 32'd0);

    // Continuous contention: grants alternate starting with m0.
    idle_masters();
    m_cyc[0] = 1'b1;
    m_cyc[1] = 1'b1;
    do_reset();
    auto_m[0] = 1'b1;
    auto_m[1] = 1'b1;
    req_pct   = 100;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 4; i++) begin
      cycle();
      if (obs_ack[0]) begin grants[cnt] = 0; cnt++; end
      else if (obs_ack[1]) begin grants[cnt] = 1; cnt++; end
    end
    check_val("rr_count", 32'(cnt), 32'd4);
    for (int i = 0; i < cnt; i++) check_val("rr_order", 32'(grants[i]), 32'(i % 2));

    // m1 write with a dead slave times out in the 5th bus cycle.
    idle_masters();
    do_reset();
    slave_mode = 1;
    m_cyc[1] = 1'b1;
    m_we[1]  = 1'b1;
    nb = 0; got = 1'b0; seen_tmo = 1'b0; seen_rdt = '0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (obs_cyc) nb++;
      if (obs_ack[1]) begin
        got = 1'b1; seen_tmo = obs_tmo; seen_rdt = obs_rdt[1];
        break;
      end
    end
    check_val("tmo_ack_seen", 32'(got), 32'd1);
    check_val("tmo_bus_cycles", 32'(nb), 32'd5);
    check_val("tmo_pulse", 32'(seen_tmo), 32'd1);
    check_val("tmo_rdt", seen_rdt, ERRW);
    m_cyc[1] = 1'b0;
    cycle();
    check_val("tmo_err_count", 32'(obs_err), 32'd1);

    // 300 consecutive timeouts saturate the error counter.
    idle_masters();
    do_reset();
    slave_mode = 1;
    auto_m[0]  = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5000 && cnt < 300; i++) begin
      cycle();
      if (obs_ack[0]) cnt++;
    end
    check_val("sat_timeouts", 32'(cnt), 32'd300);
    idle_masters();
    cycle();
    check_val("sat_err_count", 32'(obs_err), 32'd255);

    // m0 aborts while the slave acks; pending m1 is granted afterwards.
    do_reset();
    slave_mode = 0;
    m_cyc[0] = 1'b1;
    cycle();
    m_cyc[0] = 1'b0;
    m_cyc[1] = 1'b1;
    s_ack    = 1'b1;
    cycle();
    check_val("abort_no_ack", 32'(obs_ack[0]), 32'd0);
    s_ack = 1'b0;
    cycle();
    check_val("abort_idle", 32'(obs_cyc), 32'd0);
    cycle();
    check_val("abort_m1_grant", 32'(obs_cyc), 32'd1);
    s_ack = 1'b1;
    cycle();
    check_val("abort_m1_ack", 32'(obs_ack[1]), 32'd1);
    s_ack    = 1'b0;
    m_cyc[1] = 1'b0;
    cycle();

    // Reset during BUSY1 with the ack due drops the cycle.
    idle_masters();
    do_reset();
    slave_mode = 2;
    m_cyc[1] = 1'b1;
    cycle();
    cycle();
    i_rst_n = 1'b0;
    cycle();
    check_val("rst_no_ack1", 32'(obs_ack[1]), 32'd0);
    m_cyc[0] = 1'b1;
    cycle();
    check_val("rst_cyc_low", 32'(obs_cyc), 32'd0);
    i_rst_n = 1'b1;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_ack[0] || obs_ack[1]) begin
        first = obs_ack[1] ? 1 : 0;
        break;
      end
    end
    check_val("rst_first_grant", 32'(first), 32'd0);
    idle_masters();
    s_ack = 1'b0;
    cycle();

    // Random traffic with aborts and a flaky slave.
    do_reset();
    slave_mode = 3;
    auto_m[0]  = 1'b1;
    auto_m[1]  = 1'b1;
    req_pct    = 30;
    abort_en   = 1'b1;
    for (int i = 0; i < 1500; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
